// File: rtl/alu_issue_stage.sv
// In-order issue stage around a combinational ALU: operand FIFO with retire-snoop,
// head-of-queue forwarding from the result register, and a valid/ready result port.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      in_op_i,
  input  logic [4:0]      in_rd_i,
  input  logic [4:0]      in_rs1_i,
  input  logic [4:0]      in_rs2_i,
  input  logic [XLEN-1:0] in_rs1_val_i,
  input  logic [XLEN-1:0] in_rs2_val_i,
  input  logic            in_use_imm_i,
  input  logic [XLEN-1:0] in_imm_i,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [4:0]      op_o,
  input  logic [XLEN-1:0] alu_res_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      out_rd_o,
  output logic [XLEN-1:0] out_data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] b_val;
    logic            use_imm;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_out_valid;
  logic [4:0]      r_out_rd;
  logic [XLEN-1:0] r_out_data;

  entry_t w_head, w_in;
  logic   w_empty, w_push, w_fire, w_retire, w_snoop, w_fwd_ok;

  assign w_empty    = (r_count == '0);
  assign in_ready_o = (r_count != FULL);
  assign w_push     = in_valid_i && in_ready_o;
  assign w_retire   = r_out_valid && out_ready_i;
  assign w_snoop    = w_retire && (r_out_rd != 5'd0);
  assign w_fire     = !w_empty && (!r_out_valid || out_ready_i);
  assign w_fwd_ok   = r_out_valid && (r_out_rd != 5'd0);
  assign w_head     = r_mem[r_rd_ptr];

  assign out_valid_o = r_out_valid;
  assign out_rd_o    = r_out_rd;
  assign out_data_o  = r_out_data;

  // Incoming entry also sees a same-cycle retirement, else it would keep a stale value.
  always_comb begin
    w_in.op      = in_op_i;
    w_in.rd      = in_rd_i;
    w_in.rs1     = in_rs1_i;
    w_in.rs2     = in_rs2_i;
    w_in.use_imm = in_use_imm_i;
    w_in.rs1_val = (w_snoop && in_rs1_i == r_out_rd) ? r_out_data : in_rs1_val_i;
    if (in_use_imm_i)
      w_in.b_val = in_imm_i;
    else
      w_in.b_val = (w_snoop && in_rs2_i == r_out_rd) ? r_out_data : in_rs2_val_i;
  end

  always_comb begin
    a_o  = '0;
    b_o  = '0;
    op_o = '0;
    if (!w_empty) begin
      op_o = w_head.op;
      a_o  = (w_fwd_ok && r_out_rd == w_head.rs1) ? r_out_data : w_head.rs1_val;
      if (w_head.use_imm)
        b_o = w_head.b_val;
      else
        b_o = (w_fwd_ok && r_out_rd == w_head.rs2) ? r_out_data : w_head.b_val;
    end
  end

  // Snooping every slot is safe: stale slots are overwritten before they become valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (w_snoop) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].rs1 == r_out_rd)
            r_mem[i].rs1_val <= r_out_data;
          if (!r_mem[i].use_imm && r_mem[i].rs2 == r_out_rd)
            r_mem[i].b_val <= r_out_data;
        end
      end
      if (w_push)
        r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_fire)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= w_head.rd;
        r_out_data  <= alu_res_i;
      end else if (w_retire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
